// File: rtl/rs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_pkg
//  Description : Shared definitions for decode, dispatch_queue and the
//                unified reservation station: bundle width, per-cycle bundle
//                limit, unit-field location and unit codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package rs_pkg;

  localparam int BWIDTH      = 57;  // bundle width in bits
  localparam int MAX_BUNDLES = 4;   // bundles moved per cycle on any interface

  // Position of the execution-unit code inside a bundle
  localparam int UNIT_HI = 41;
  localparam int UNIT_LO = 39;

  typedef enum logic [2:0] {
    UNIT_ASB   = 3'd0,
    UNIT_LOGIC = 3'd1,
    UNIT_LOAD  = 3'd2,
    UNIT_STORE = 3'd3,
    UNIT_ENV   = 3'd4
  } unit_e;

  // Counts above MAX_BUNDLES are treated as MAX_BUNDLES
  function automatic logic [2:0] clamp_bundles(input logic [2:0] n);
    return (n > 3'(MAX_BUNDLES)) ? 3'(MAX_BUNDLES) : n;
  endfunction

endpackage : rs_pkg
`default_nettype wire

// File: rtl/dq_storage.sv
`default_nettype none
// ============================================================================
//  Module      : dq_storage
//  Description : DEPTH x BWIDTH register array with NPORTS indexed write ports
//                and NPORTS indexed (combinational) read ports.
//  Revision    : 1.0 - initial release
//
//  Ports
//    i_clk    : clock
//    i_rst    : asynchronous active-high reset, clears every entry
//    i_we     : per-port write enable
//    i_waddr  : per-port write index
//    i_wdata  : per-port write data
//    i_raddr  : per-port read index
//    o_rdata  : per-port read data
// ============================================================================
module dq_storage
  import rs_pkg::MAX_BUNDLES;
#(
  parameter int BWIDTH = 57,
  parameter int DEPTH  = 16,
  parameter int NPORTS = MAX_BUNDLES,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NPORTS-1:0]              i_we,
  input  logic [NPORTS-1:0][AW-1:0]      i_waddr,
  input  logic [NPORTS-1:0][BWIDTH-1:0]  i_wdata,
  input  logic [NPORTS-1:0][AW-1:0]      i_raddr,
  output logic [NPORTS-1:0][BWIDTH-1:0]  o_rdata
);

  logic [BWIDTH-1:0] mem_q [DEPTH];
  logic [BWIDTH-1:0] mem_d [DEPTH];

  // Write ports never collide: the caller writes consecutive indices and
  // NPORTS < DEPTH.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < NPORTS; k++) begin
      if (i_we[k]) mem_d[i_waddr[k]] = i_wdata[k];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar k = 0; k < NPORTS; k++) begin : g_rd
    assign o_rdata[k] = mem_q[i_raddr[k]];
  end

endmodule : dq_storage
`default_nettype wire

// File: rtl/dispatch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : dispatch_queue
//  Description : Circular in-order bundle buffer between decode/rename and the
//                unified reservation station. Accepts up to four bundles per
//                cycle (all-or-nothing), presents the oldest four, and retires
//                however many the reservation station consumed.
//  Revision    : 1.0 - initial release
//
//  Ports
//    i_clk              : clock
//    i_rst              : asynchronous active-high reset
//    i_flush            : discard all entries
//    i_push_bundle0..3  : decoded bundles, 0 oldest
//    i_push_count       : valid push bundles (values above 4 act as 4)
//    o_push_ack         : push accepted this cycle (combinational)
//    o_free             : free entries (registered)
//    o_bundle0..3       : oldest four entries, head first, 0 when invalid
//    o_count            : valid bundles on o_bundle*, min(occupancy, 4)
//    i_pop_count        : bundles consumed this cycle, from o_bundle0
//    o_empty            : occupancy == 0
// ============================================================================
module dispatch_queue
  import rs_pkg::MAX_BUNDLES, rs_pkg::clamp_bundles;
#(
  parameter int BWIDTH  = rs_pkg::BWIDTH,
  parameter int DEPTH   = 16,
  localparam int CBITS  = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic [BWIDTH-1:0] i_push_bundle0,
  input  logic [BWIDTH-1:0] i_push_bundle1,
  input  logic [BWIDTH-1:0] i_push_bundle2,
  input  logic [BWIDTH-1:0] i_push_bundle3,
  input  logic [2:0]        i_push_count,
  output logic              o_push_ack,
  output logic [CBITS-1:0]  o_free,
  output logic [BWIDTH-1:0] o_bundle0,
  output logic [BWIDTH-1:0] o_bundle1,
  output logic [BWIDTH-1:0] o_bundle2,
  output logic [BWIDTH-1:0] o_bundle3,
  output logic [2:0]        o_count,
  input  logic [2:0]        i_pop_count,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CBITS-1:0] occ_q,  occ_d;
  logic [CBITS-1:0] free_q, free_d;

  logic [2:0] push_n;     // clamped push request
  logic [2:0] push_eff;   // bundles actually written
  logic [2:0] pop_eff;    // bundles actually retired
  logic [2:0] count;
  logic       push_ack;

  logic [MAX_BUNDLES-1:0]             we;
  logic [MAX_BUNDLES-1:0][AW-1:0]     waddr;
  logic [MAX_BUNDLES-1:0][AW-1:0]     raddr;
  logic [MAX_BUNDLES-1:0][BWIDTH-1:0] wdata;
  logic [MAX_BUNDLES-1:0][BWIDTH-1:0] rdata;
  logic [MAX_BUNDLES-1:0][BWIDTH-1:0] shown;

  always_comb begin
    push_n = clamp_bundles(i_push_count);
    // Room is judged on registered free space only, so a same-cycle pop
    // never feeds the push acknowledge.
    push_ack = !i_rst && !i_flush && (push_n != 3'd0)
               && (CBITS'(push_n) <= free_q);
    push_eff = push_ack ? push_n : 3'd0;

    count   = (occ_q > CBITS'(MAX_BUNDLES)) ? 3'(MAX_BUNDLES) : occ_q[2:0];
    pop_eff = (i_pop_count > count) ? count : i_pop_count;

    if (i_flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      head_d = head_q + AW'(pop_eff);
      tail_d = tail_q + AW'(push_eff);
      occ_d  = occ_q + CBITS'(push_eff) - CBITS'(pop_eff);
    end
    free_d = CBITS'(DEPTH) - occ_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      free_q <= CBITS'(DEPTH);
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      free_q <= free_d;
    end
  end

  assign wdata[0] = i_push_bundle0;
  assign wdata[1] = i_push_bundle1;
  assign wdata[2] = i_push_bundle2;
  assign wdata[3] = i_push_bundle3;

  // Pointer sums wrap naturally because DEPTH is a power of two.
  for (genvar k = 0; k < MAX_BUNDLES; k++) begin : g_port
    assign we[k]    = push_ack && (3'(k) < push_n);
    assign waddr[k] = tail_q + AW'(k);
    assign raddr[k] = head_q + AW'(k);
    assign shown[k] = (3'(k) < count) ? rdata[k] : '0;
  end

  dq_storage #(
    .BWIDTH (BWIDTH),
    .DEPTH  (DEPTH),
    .NPORTS (MAX_BUNDLES)
  ) u_storage (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (we),
    .i_waddr (waddr),
    .i_wdata (wdata),
    .i_raddr (raddr),
    .o_rdata (rdata)
  );

  assign o_push_ack = push_ack;
  assign o_free     = free_q;
  assign o_count    = count;
  assign o_empty    = (occ_q == '0);
  assign o_bundle0  = shown[0];
  assign o_bundle1  = shown[1];
  assign o_bundle2  = shown[2];
  assign o_bundle3  = shown[3];

endmodule : dispatch_queue
`default_nettype wire

// File: tb/tb_dispatch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dispatch_queue
//  Description : Directed self-checking bench for dispatch_queue (DEPTH 16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_queue;

  localparam int BW = 57;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [BW-1:0] pb0, pb1, pb2, pb3;
  logic [2:0]    push_count;
  logic [2:0]    pop_count;
  logic          push_ack;
  logic [4:0]    free;
  logic [BW-1:0] ob0, ob1, ob2, ob3;
  logic [2:0]    count;
  logic          empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dispatch_queue dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_flush        (flush),
    .i_push_bundle0 (pb0),
    .i_push_bundle1 (pb1),
    .i_push_bundle2 (pb2),
    .i_push_bundle3 (pb3),
    .i_push_count   (push_count),
    .o_push_ack     (push_ack),
    .o_free         (free),
    .o_bundle0      (ob0),
    .o_bundle1      (ob1),
    .o_bundle2      (ob2),
    .o_bundle3      (ob3),
    .o_count        (count),
    .i_pop_count    (pop_count),
    .o_empty        (empty)
  );

  task automatic idle();
    flush = 1'b0; push_count = 3'd0; pop_count = 3'd0;
    pb0 = '0; pb1 = '0; pb2 = '0; pb3 = '0;
  endtask

  // Advance one edge, sample 1ns later, then drop all requests.
  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic drive(input int pc, input int base, input int pop, input logic fl);
    push_count = 3'(pc); pop_count = 3'(pop); flush = fl;
    pb0 = BW'(base); pb1 = BW'(base + 1); pb2 = BW'(base + 2); pb3 = BW'(base + 3);
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; push_count = 3'd1;
    #2;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset.count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset.empty got %0b exp 1", empty); end
    checks++; if (free !== 5'd16) begin errors++; $display("FAIL reset.free got %0d exp 16", free); end
    checks++; if (push_ack !== 1'b0) begin errors++; $display("FAIL reset.ack got %0b exp 0", push_ack); end
    checks++; if (ob0 !== '0) begin errors++; $display("FAIL reset.bundle0 got %0h exp 0", ob0); end
    @(posedge clk); #1;
    rst = 1'b0; idle();
  endtask

  task automatic test_push_basic();
    drive(3, 'hA, 0, 1'b0); pb1 = BW'('hB); pb2 = BW'('hC); pb3 = '0;
    #1;
    checks++; if (push_ack !== 1'b1) begin errors++; $display("FAIL basic.ack got %0b exp 1", push_ack); end
    step();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL basic.count got %0d exp 3", count); end
    checks++; if (ob0 !== BW'('hA)) begin errors++; $display("FAIL basic.b0 got %0h exp a", ob0); end
    checks++; if (ob1 !== BW'('hB)) begin errors++; $display("FAIL basic.b1 got %0h exp b", ob1); end
    checks++; if (ob2 !== BW'('hC)) begin errors++; $display("FAIL basic.b2 got %0h exp c", ob2); end
    checks++; if (ob3 !== '0) begin errors++; $display("FAIL basic.b3 got %0h exp 0", ob3); end
    checks++; if (free !== 5'd13) begin errors++; $display("FAIL basic.free got %0d exp 13", free); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL basic.empty got %0b exp 0", empty); end
  endtask

  // Continues from the three entries A, B, C.
  task automatic test_full();
    for (int i = 0; i < 3; i++) begin
      drive(4, 'h10 + 4 * i, 0, 1'b0); step();
    end
    checks++; if (free !== 5'd1) begin errors++; $display("FAIL full.free15 got %0d exp 1", free); end
    drive(2, 'h1C, 0, 1'b0); #1;
    checks++; if (push_ack !== 1'b0) begin errors++; $display("FAIL full.ack2 got %0b exp 0", push_ack); end
    step();
    checks++; if (free !== 5'd1) begin errors++; $display("FAIL full.hold got %0d exp 1", free); end
    drive(1, 'h1C, 0, 1'b0); #1;
    checks++; if (push_ack !== 1'b1) begin errors++; $display("FAIL full.ack1 got %0b exp 1", push_ack); end
    step();
    checks++; if (free !== 5'd0) begin errors++; $display("FAIL full.free0 got %0d exp 0", free); end
    drive(1, 'h1D, 1, 1'b0); #1;
    checks++; if (push_ack !== 1'b0) begin errors++; $display("FAIL full.ackfull got %0b exp 0", push_ack); end
    step();
    checks++; if (free !== 5'd1) begin errors++; $display("FAIL full.popfree got %0d exp 1", free); end
    checks++; if (ob0 !== BW'('hB)) begin errors++; $display("FAIL full.popb0 got %0h exp b", ob0); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full.count got %0d exp 4", count); end
  endtask

  task automatic test_push_clamp();
    do_reset();
    drive(7, 'h20, 0, 1'b0); #1;
    checks++; if (push_ack !== 1'b1) begin errors++; $display("FAIL clamp.ack got %0b exp 1", push_ack); end
    step();
    checks++; if (free !== 5'd12) begin errors++; $display("FAIL clamp.free got %0d exp 12", free); end
    checks++; if (ob3 !== BW'('h23)) begin errors++; $display("FAIL clamp.b3 got %0h exp 23", ob3); end
  endtask

  task automatic test_simul();
    do_reset();
    drive(4, 'h30, 0, 1'b0); step();
    drive(2, 'h34, 0, 1'b0); step();
    checks++; if (free !== 5'd10) begin errors++; $display("FAIL simul.free6 got %0d exp 10", free); end
    drive(4, 'h36, 2, 1'b0); #1;
    checks++; if (push_ack !== 1'b1) begin errors++; $display("FAIL simul.ack got %0b exp 1", push_ack); end
    step();
    checks++; if (free !== 5'd8) begin errors++; $display("FAIL simul.free8 got %0d exp 8", free); end
    checks++; if (ob0 !== BW'('h32)) begin errors++; $display("FAIL simul.b0 got %0h exp 32", ob0); end
    checks++; if (ob3 !== BW'('h35)) begin errors++; $display("FAIL simul.b3 got %0h exp 35", ob3); end
    drive(4, 'h3A, 0, 1'b0); step();
    drive(2, 'h3E, 0, 1'b0); step();
    checks++; if (free !== 5'd2) begin errors++; $display("FAIL simul.free14 got %0d exp 2", free); end
    drive(4, 'h50, 4, 1'b0); #1;
    checks++; if (push_ack !== 1'b0) begin errors++; $display("FAIL simul.nack got %0b exp 0", push_ack); end
    step();
    checks++; if (free !== 5'd6) begin errors++; $display("FAIL simul.free10 got %0d exp 6", free); end
    checks++; if (ob0 !== BW'('h36)) begin errors++; $display("FAIL simul.b0after got %0h exp 36", ob0); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4, 'h100 + 4 * i, 0, 1'b0); step();
    end
    drive(2, 'h10C, 0, 1'b0); step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 4, 1'b0); step();
    end
    drive(0, 0, 2, 1'b0); step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap.empty got %0b exp 1", empty); end
    drive(4, 'h40, 0, 1'b0); step();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL wrap.count got %0d exp 4", count); end
    checks++; if (ob0 !== BW'('h40)) begin errors++; $display("FAIL wrap.b0 got %0h exp 40", ob0); end
    checks++; if (ob1 !== BW'('h41)) begin errors++; $display("FAIL wrap.b1 got %0h exp 41", ob1); end
    checks++; if (ob2 !== BW'('h42)) begin errors++; $display("FAIL wrap.b2 got %0h exp 42", ob2); end
    checks++; if (ob3 !== BW'('h43)) begin errors++; $display("FAIL wrap.b3 got %0h exp 43", ob3); end
    drive(0, 0, 3, 1'b0); step();
    checks++; if (ob0 !== BW'('h43)) begin errors++; $display("FAIL wrap.popb0 got %0h exp 43", ob0); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL wrap.popcount got %0d exp 1", count); end
    checks++; if (ob1 !== '0) begin errors++; $display("FAIL wrap.popb1 got %0h exp 0", ob1); end
    checks++; if (free !== 5'd15) begin errors++; $display("FAIL wrap.free got %0d exp 15", free); end
  endtask

  // Continues from one entry (0x43).
  task automatic test_overpop();
    drive(1, 'h44, 0, 1'b0); step();
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL overpop.count got %0d exp 2", count); end
    drive(0, 0, 4, 1'b0); step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL overpop.empty got %0b exp 1", empty); end
    checks++; if (free !== 5'd16) begin errors++; $display("FAIL overpop.free got %0d exp 16", free); end
    drive(0, 0, 4, 1'b0); step();
    checks++; if (free !== 5'd16) begin errors++; $display("FAIL overpop.emptypop got %0d exp 16", free); end
    drive(1, 'h45, 0, 1'b0); step();
    checks++; if (ob0 !== BW'('h45)) begin errors++; $display("FAIL overpop.b0 got %0h exp 45", ob0); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL overpop.count1 got %0d exp 1", count); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(4, 'h60, 0, 1'b0); step();
    drive(4, 'h64, 0, 1'b0); step();
    drive(1, 'h68, 0, 1'b0); step();
    checks++; if (free !== 5'd7) begin errors++; $display("FAIL flush.free9 got %0d exp 7", free); end
    drive(4, 'h70, 1, 1'b1); #1;
    checks++; if (push_ack !== 1'b0) begin errors++; $display("FAIL flush.ack got %0b exp 0", push_ack); end
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush.count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush.empty got %0b exp 1", empty); end
    checks++; if (free !== 5'd16) begin errors++; $display("FAIL flush.free got %0d exp 16", free); end
    checks++; if (ob0 !== '0) begin errors++; $display("FAIL flush.b0 got %0h exp 0", ob0); end
    drive(2, 'h78, 0, 1'b0); step();
    checks++; if (ob0 !== BW'('h78)) begin errors++; $display("FAIL flush.repush got %0h exp 78", ob0); end
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL flush.recount got %0d exp 2", count); end
  endtask

  // Continues from two entries.
  task automatic test_async_reset();
    drive(4, 'h80, 0, 1'b0); step();
    drive(4, 'h84, 1, 1'b0);
    #3 rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL arst.count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst.empty got %0b exp 1", empty); end
    checks++; if (free !== 5'd16) begin errors++; $display("FAIL arst.free got %0d exp 16", free); end
    checks++; if (push_ack !== 1'b0) begin errors++; $display("FAIL arst.ack got %0b exp 0", push_ack); end
    checks++; if (ob0 !== '0) begin errors++; $display("FAIL arst.b0 got %0h exp 0", ob0); end
    #1 rst = 1'b0;
    idle();
    drive(1, 'h9F, 0, 1'b0); #1;
    checks++; if (push_ack !== 1'b1) begin errors++; $display("FAIL arst.firstack got %0b exp 1", push_ack); end
    step();
    checks++; if (ob0 !== BW'('h9F)) begin errors++; $display("FAIL arst.b0after got %0h exp 9f", ob0); end
    checks++; if (free !== 5'd15) begin errors++; $display("FAIL arst.freeafter got %0d exp 15", free); end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_push_basic();
    test_full();
    test_push_clamp();
    test_simul();
    test_wrap();
    test_overpop();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_dispatch_queue
`default_nettype wire
